// File: rtl/dbus_arbiter.sv
`timescale 1ns/1ps
// dbus_arbiter
// Shares the external data bus between the core MEM-stage port and one
// secondary requester (DMA/debug). The core has priority. After STARVE_LIMIT
// consecutive core grants while dmaReq is waiting, the next grant goes to the
// secondary requester. Every access waits for busReady, and coreStall holds
// the pipeline while a core access is pending.
//
// Optional feature: define DBUS_ARB_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES wait cycles. An abort pulses busError and completes the
// access with read data 0. When the macro is undefined, busError is tied to 0.
//
// Ports:
//   clk, arstn          clock, synchronous active-low reset
//   core*               core request fields in; coreLdData, coreStall out
//   dma*                secondary request fields in; dmaGnt, dmaRData out
//   bus*                registered bus address/data/enables/mask out;
//                       busRData, busReady in; busError out
//
// State table
//   state | meaning
//   IDLE  | bus enables low, arbitrating
//   CORE  | core access on the bus, waiting for busReady
//   DMA   | secondary access on the bus, waiting for busReady
module dbus_arbiter #(
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        arstn,
   input  logic [31:0] coreAddr,
   input  logic [31:0] coreStData,
   input  logic        coreLdSignal,
   input  logic        coreStSignal,
   input  logic [3:0]  coreWriteMask,
   output logic [31:0] coreLdData,
   output logic        coreStall,
   input  logic        dmaReq,
   input  logic        dmaWe,
   input  logic [31:0] dmaAddr,
   input  logic [31:0] dmaWData,
   input  logic [3:0]  dmaMask,
   output logic        dmaGnt,
   output logic [31:0] dmaRData,
   output logic [31:0] busAddr,
   output logic [31:0] busWData,
   output logic        busRdEn,
   output logic        busWrEn,
   output logic [3:0]  busMask,
   input  logic [31:0] busRData,
   input  logic        busReady,
   output logic        busError
);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : gBadStarveLimit
      $error("dbus_arbiter: STARVE_LIMIT out of range 1..15");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : gBadTimeout
      $error("dbus_arbiter: TIMEOUT_CYCLES out of range 1..1023");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CORE = 2'd1,
      DMA  = 2'd2
   } arbStateT;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   arbStateT    state;
   arbStateT    nextState;
   logic [3:0]  starveCnt;
   logic        coreReq;
   logic        starveHit;
   logic        grantCore;
   logic        grantDma;
   logic        accDone;
   logic        abort;
   logic        coreDone;
   logic [31:0] rdData;

   assign coreReq   = coreLdSignal | coreStSignal;
   assign starveHit = dmaReq && (starveCnt == STARVE_MAX);

`ifdef DBUS_ARB_TIMEOUT_EN
   localparam logic [9:0] WAIT_MAX = 10'(TIMEOUT_CYCLES);

   logic [9:0] waitCnt;

   always_ff @(posedge clk) begin
      if (!arstn) begin
         waitCnt <= '0;
      end else if (grantCore || grantDma) begin
         waitCnt <= '0;
      end else if (state != IDLE && !busReady && !abort) begin
         waitCnt <= waitCnt + 10'd1;
      end
   end

   // A late busReady in the limit cycle still counts as a normal completion.
   assign abort = (state != IDLE) && !busReady && (waitCnt == WAIT_MAX);
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!arstn) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      grantCore = 1'b0;
      grantDma  = 1'b0;
      accDone   = 1'b0;
      case (state)
         IDLE: begin
            if (coreReq && !starveHit) begin
               grantCore = 1'b1;
               nextState = CORE;
            end else if (dmaReq) begin
               grantDma  = 1'b1;
               nextState = DMA;
            end
         end
         CORE, DMA: begin
            if (busReady || abort) begin
               accDone   = 1'b1;
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Completion outputs are combinational. While reset is asserted they are
   // held at 0, because the state register has not been cleared yet.
   assign coreDone   = accDone && (state == CORE);
   assign rdData     = abort ? 32'd0 : busRData;
   assign coreStall  = arstn && coreReq && !coreDone;
   assign coreLdData = (arstn && coreDone) ? rdData : 32'd0;
   assign dmaGnt     = arstn && accDone && (state == DMA);
   assign dmaRData   = dmaGnt ? rdData : 32'd0;
   assign busError   = arstn && abort;

   // The count only grows while the secondary requester is waiting.
   // Dropping dmaReq or granting it restarts the count.
   always_ff @(posedge clk) begin
      if (!arstn || !dmaReq || grantDma) begin
         starveCnt <= '0;
      end else if (grantCore && starveCnt != STARVE_MAX) begin
         starveCnt <= starveCnt + 4'd1;
      end
   end

   // Load and store together act as a store. On completion only the enables
   // drop; address, data and mask keep their last values.
   always_ff @(posedge clk) begin
      if (!arstn) begin
         busAddr  <= '0;
         busWData <= '0;
         busMask  <= '0;
         busRdEn  <= 1'b0;
         busWrEn  <= 1'b0;
      end else if (grantCore) begin
         busAddr  <= coreAddr;
         busWData <= coreStData;
         busMask  <= coreWriteMask;
         busWrEn  <= coreStSignal;
         busRdEn  <= !coreStSignal;
      end else if (grantDma) begin
         busAddr  <= dmaAddr;
         busWData <= dmaWData;
         busMask  <= dmaMask;
         busWrEn  <= dmaWe;
         busRdEn  <= !dmaWe;
      end else if (accDone) begin
         busRdEn  <= 1'b0;
         busWrEn  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dbus_arbiter.sv
`timescale 1ns/1ps
module tb_dbus_arbiter;
   localparam int STARVE_LIMIT   = 4;
   localparam int TIMEOUT_CYCLES = 8;

   logic        clk = 1'b0;
   logic        arstn;
   logic [31:0] coreAddr, coreStData, coreLdData;
   logic        coreLdSignal, coreStSignal, coreStall;
   logic [3:0]  coreWriteMask;
   logic        dmaReq, dmaWe, dmaGnt;
   logic [31:0] dmaAddr, dmaWData, dmaRData;
   logic [3:0]  dmaMask;
   logic [31:0] busAddr, busWData, busRData;
   logic        busRdEn, busWrEn, busReady, busError;
   logic [3:0]  busMask;

   always #5 clk = ~clk;

   dbus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .clk(clk), .arstn(arstn),
      .coreAddr(coreAddr), .coreStData(coreStData), .coreLdSignal(coreLdSignal),
      .coreStSignal(coreStSignal), .coreWriteMask(coreWriteMask),
      .coreLdData(coreLdData), .coreStall(coreStall),
      .dmaReq(dmaReq), .dmaWe(dmaWe), .dmaAddr(dmaAddr), .dmaWData(dmaWData),
      .dmaMask(dmaMask), .dmaGnt(dmaGnt), .dmaRData(dmaRData),
      .busAddr(busAddr), .busWData(busWData), .busRdEn(busRdEn), .busWrEn(busWrEn),
      .busMask(busMask), .busRData(busRData), .busReady(busReady), .busError(busError)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkB(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the access currently on the bus, described as a transaction.
   typedef struct packed {
      logic        busy;
      logic        isDma;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
   } accT;

   accT cur;
   int  waited;
   int  coreRun;
   bit  mdlValid = 1'b0;
   bit  expStall, expGnt;

   logic        snapStall, snapGnt, snapErr, snapRdEn, snapWrEn, snapCoreDone;
   logic [31:0] snapAddr, snapLdData, snapRData, lastWrData;
   logic [3:0]  lastWrMask;
   int          nStall, nRdEn, nWrEn, nGnt, nCoreDone;

   task automatic clearCounts();
      nStall = 0; nRdEn = 0; nWrEn = 0; nGnt = 0; nCoreDone = 0;
   endtask

   task automatic modelCycle();
      bit          req, timeoutNow, done;
      logic [31:0] eRd;
      req        = coreLdSignal | coreStSignal;
      timeoutNow = 1'b0;
`ifdef DBUS_ARB_TIMEOUT_EN
      timeoutNow = cur.busy && !busReady && (waited == TIMEOUT_CYCLES);
`endif
      done     = cur.busy && (busReady || timeoutNow);
      expStall = arstn && req && !(done && !cur.isDma);
      expGnt   = arstn && done && cur.isDma;
      eRd      = timeoutNow ? 32'd0 : busRData;

      snapStall = coreStall; snapGnt = dmaGnt; snapErr = busError;
      snapRdEn = busRdEn; snapWrEn = busWrEn; snapAddr = busAddr;
      snapLdData = coreLdData; snapRData = dmaRData;
      snapCoreDone = arstn && req && !coreStall;
      nStall += int'(coreStall); nRdEn += int'(busRdEn); nWrEn += int'(busWrEn);
      nGnt += int'(dmaGnt); nCoreDone += int'(snapCoreDone);
      if (busWrEn) begin lastWrMask = busMask; lastWrData = busWData; end

      if (mdlValid) begin
         chkB("coreStall", coreStall, expStall);
         chkB("dmaGnt", dmaGnt, expGnt);
         chkB("busError", busError, arstn && timeoutNow);
         chkB("busRdEn", busRdEn, cur.busy && !cur.we);
         chkB("busWrEn", busWrEn, cur.busy && cur.we);
         chk("busAddr", busAddr, cur.addr);
         chk("busWData", busWData, cur.wdata);
         chk("busMask", {28'd0, busMask}, {28'd0, cur.mask});
         if (!arstn) begin
            chk("coreLdData in reset", coreLdData, 32'd0);
            chk("dmaRData in reset", dmaRData, 32'd0);
         end else if (done && !cur.isDma && !cur.we) begin
            chk("coreLdData", coreLdData, eRd);
         end else if (expGnt && !cur.we) begin
            chk("dmaRData", dmaRData, eRd);
         end
      end

      if (!arstn) begin
         cur = '0; waited = 0; coreRun = 0; mdlValid = 1'b1;
      end else begin
         if (cur.busy) begin
            if (done) cur.busy = 1'b0;
            else if (!busReady) waited++;
         end else if (req && !(dmaReq && coreRun == STARVE_LIMIT)) begin
            cur.busy = 1'b1; cur.isDma = 1'b0; cur.we = coreStSignal;
            cur.addr = coreAddr; cur.wdata = coreStData; cur.mask = coreWriteMask;
            waited = 0;
            if (dmaReq && coreRun < STARVE_LIMIT) coreRun++;
         end else if (dmaReq) begin
            cur.busy = 1'b1; cur.isDma = 1'b1; cur.we = dmaWe;
            cur.addr = dmaAddr; cur.wdata = dmaWData; cur.mask = dmaMask;
            waited = 0; coreRun = 0;
         end
         if (!dmaReq) coreRun = 0;
      end
   endtask

   task automatic step();
      @(negedge clk);
      modelCycle();
      @(posedge clk);
      #1;
   endtask

   int coreBeforeGnt, rise, errAt;

   initial begin
      arstn = 1'b0; coreAddr = '0; coreStData = '0; coreLdSignal = 1'b0;
      coreStSignal = 1'b0; coreWriteMask = '0; dmaReq = 1'b0; dmaWe = 1'b0;
      dmaAddr = '0; dmaWData = '0; dmaMask = '0; busRData = '0; busReady = 1'b0;
      cur = '0; waited = 0; coreRun = 0;
      lastWrMask = '0; lastWrData = '0;
      clearCounts();

      repeat (3) step();
      chkB("reset busRdEn", snapRdEn, 1'b0);
      chkB("reset busWrEn", snapWrEn, 1'b0);
      chk("reset busAddr", snapAddr, 32'd0);
      chkB("reset coreStall", snapStall, 1'b0);

      // core load with two wait states
      arstn = 1'b1; coreLdSignal = 1'b1; coreAddr = 32'h100; busReady = 1'b0;
      clearCounts();
      step(); step(); step();
      busReady = 1'b1; busRData = 32'hDEADBEEF;
      step();
      chk("load data", snapLdData, 32'hDEADBEEF);
      chkB("load stall at completion", snapStall, 1'b0);
      coreLdSignal = 1'b0;
      step(); step();
      chk("load stall cycles", nStall, 3);
      chk("load rdEn cycles", nRdEn, 3);

      // core store, bus always ready
      coreStSignal = 1'b1; coreWriteMask = 4'h3; coreStData = 32'h1234; coreAddr = 32'h200;
      clearCounts();
      step(); step();
      coreStSignal = 1'b0;
      step(); step();
      chk("store stall cycles", nStall, 1);
      chk("store wrEn cycles", nWrEn, 1);
      chk("store rdEn cycles", nRdEn, 0);
      chk("store mask", {28'd0, lastWrMask}, 32'h3);
      chk("store data", lastWrData, 32'h1234);

      // starvation bound with a continuous core load stream
      dmaReq = 1'b1; dmaWe = 1'b0; dmaAddr = 32'h300; coreLdSignal = 1'b1;
      coreAddr = 32'h1000; busReady = 1'b1;
      clearCounts(); coreBeforeGnt = -1;
      for (int i = 0; i < 24; i++) begin
         busRData = $urandom;
         step();
         if (snapCoreDone) coreAddr = coreAddr + 32'd4;
         if (snapGnt) begin
            if (coreBeforeGnt < 0) coreBeforeGnt = nCoreDone;
            dmaReq = 1'b0;
         end
      end
      chk("core grants before dma", coreBeforeGnt, STARVE_LIMIT);
      chk("dma grants", nGnt, 1);
      chkB("core resumed", nCoreDone > coreBeforeGnt, 1'b1);
      coreLdSignal = 1'b0;
      step(); step();

      // simultaneous core and dma arrival
      coreLdSignal = 1'b1; coreAddr = 32'h400; dmaReq = 1'b1; dmaWe = 1'b0;
      dmaAddr = 32'h500; busReady = 1'b1; busRData = 32'hCAFEF00D;
      step();
      step();
      chkB("simul core first", snapCoreDone, 1'b1);
      chkB("simul no gnt yet", snapGnt, 1'b0);
      coreLdSignal = 1'b0;
      step();
      chkB("simul gnt idle cycle", snapGnt, 1'b0);
      step();
      chkB("simul dma gnt", snapGnt, 1'b1);
      chk("simul dmaRData", snapRData, 32'hCAFEF00D);
      chk("simul dma addr", snapAddr, 32'h500);
      dmaReq = 1'b0;
      step();

      // reset in the middle of a core access
      coreLdSignal = 1'b1; coreAddr = 32'h600; busReady = 1'b0;
      step(); step();
      arstn = 1'b0;
      step();
      chkB("midreset stall", snapStall, 1'b0);
      chkB("midreset gnt", snapGnt, 1'b0);
      chk("midreset ldData", snapLdData, 32'd0);
      arstn = 1'b1; coreLdSignal = 1'b0;
      step();
      chkB("after reset rdEn", snapRdEn, 1'b0);
      chkB("after reset wrEn", snapWrEn, 1'b0);

`ifdef DBUS_ARB_TIMEOUT_EN
      // secondary read that never sees busReady
      dmaReq = 1'b1; dmaWe = 1'b0; dmaAddr = 32'h700; busReady = 1'b0; busRData = 32'h5555AAAA;
      rise = -1; errAt = -1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (snapRdEn && rise < 0) rise = i;
         if (snapGnt) begin
            if (errAt < 0) begin
               errAt = i;
               chkB("timeout busError", snapErr, 1'b1);
               chk("timeout dmaRData", snapRData, 32'd0);
            end
            dmaReq = 1'b0;
         end
      end
      chk("timeout distance", errAt - rise, TIMEOUT_CYCLES);
`endif

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         busRData = $urandom;
         busReady = ($urandom_range(0, 99) < 60);
         if (!((coreLdSignal || coreStSignal) && expStall)) begin
            if ($urandom_range(0, 2) != 0) begin
               case ($urandom_range(0, 2))
                  0: begin coreLdSignal = 1'b1; coreStSignal = 1'b0; end
                  1: begin coreLdSignal = 1'b0; coreStSignal = 1'b1; end
                  default: begin coreLdSignal = 1'b1; coreStSignal = 1'b1; end
               endcase
               coreAddr = $urandom; coreStData = $urandom;
               coreWriteMask = 4'($urandom_range(0, 15));
            end else begin
               coreLdSignal = 1'b0; coreStSignal = 1'b0;
            end
         end
         if (!(dmaReq && !expGnt)) begin
            dmaReq = ($urandom_range(0, 1) == 1);
            dmaWe = ($urandom_range(0, 1) == 1);
            dmaAddr = $urandom; dmaWData = $urandom;
            dmaMask = 4'($urandom_range(0, 15));
         end
         arstn = ($urandom_range(0, 499) != 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Data-bus arbiter and sequencer that shares the single external data bus between the core's MEM-stage port and one secondary requester (DMA/debug). It sits between the `dm_interface` bus signals and the external memory bus. It adds wait-state support via a bus ready handshake and stalls the core pipeline while an access is outstanding. Arbitration is core-priority with a starvation bound for the secondary requester.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: maximum consecutive core grants while `dmaReq` is pending; range 1..15.
- `TIMEOUT_CYCLES`, 255: wait cycles before a bus access is aborted. Used only with `DBUS_ARB_TIMEOUT_EN`; range 1..1023.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `arstn`  in  1  reset, synchronous, active-low.
- `coreAddr`  in  32  core access address (MEM stage).
- `coreStData`  in  32  core store data.
- `coreLdSignal`  in  1  core load request.
- `coreStSignal`  in  1  core store request.
- `coreWriteMask`  in  4  core byte-write mask.
- `coreLdData`  out  32  core load data; valid in the completion cycle.
- `coreStall`  out  1  freezes the IF..MEM pipeline.
- `dmaReq`  in  1  secondary request; held until `dmaGnt`.
- `dmaWe`  in  1  1 = write, 0 = read.
- `dmaAddr`  in  32  secondary address.
- `dmaWData`  in  32  secondary write data.
- `dmaMask`  in  4  secondary byte mask.
- `dmaGnt`  out  1  one-cycle completion pulse.
- `dmaRData`  out  32  read data; valid while `dmaGnt` = 1.
- `busAddr`  out  32  registered bus address.
- `busWData`  out  32  registered bus write data.
- `busRdEn`  out  1  registered bus read enable.
- `busWrEn`  out  1  registered bus write enable.
- `busMask`  out  4  registered byte mask.
- `busRData`  in  32  bus read data; sampled when `busReady` = 1.
- `busReady`  in  1  the access completes in this cycle.
- `busError`  out  1  one-cycle timeout pulse (`DBUS_ARB_TIMEOUT_EN` only).

## Operation
- FSM states: IDLE, CORE, DMA.
- **IDLE.** Bus enables are 0.
  - Core request (`coreLdSignal|coreStSignal`) with no starvation condition: latch the core fields into the bus registers and go to CORE.
  - Starvation condition is `dmaReq && starveCnt == STARVE_LIMIT`. When it holds, or when `dmaReq` is the only request: latch the DMA fields and go to DMA.
- **CORE.** Hold the bus registers.
  - On `busReady` = 1: `coreLdData = busRData` (combinational pass-through), deassert `coreStall`, go to IDLE.
- **DMA.** Hold the bus registers.
  - On `busReady` = 1: `dmaGnt` = 1, `dmaRData = busRData`, go to IDLE.
- `coreStall = coreReq && !(state==CORE && busReady)`. Combinational; asserts in IDLE and in DMA as well.
- Core load and store both high: treat as a store (`busWrEn` = 1, `busRdEn` = 0).
- `starveCnt` (4 bit):
  - +1 on each core grant while `dmaReq` = 1.
  - Cleared on DMA grant or when `dmaReq` = 0.
  - Saturates at `STARVE_LIMIT`.
- Write accesses: the requester ignores read data. Bus enables are one-hot or zero.
- Requester fields must stay stable while a request is pending. The core guarantees this via `coreStall`; the secondary requester via the handshake. The arbiter does not re-check them after latching.

## Timing
- Reset (`arstn` low at a rising edge): state IDLE, `starveCnt` = 0, timeout counter = 0.
  - All registered bus outputs are 0; `dmaGnt` = 0 and `busError` = 0.
  - `coreStall` is forced 0 and `coreLdData`/`dmaRData` are 0 while `arstn` = 0.
- Reset mid-access: the access is dropped with no completion pulse. The requester must re-issue.
- Core access latency:
  - Request seen in IDLE at cycle N: bus enables are high from N+1.
  - Earliest completion is N+1 (`busReady` already high), i.e. one stall cycle.
  - Each low `busReady` cycle adds one stall cycle.
- DMA latency: `dmaReq` at N gives `dmaGnt` at N+1 at the earliest. `dmaReq` may drop in the cycle after `dmaGnt`.
- Back-to-back: every completion returns to IDLE, so there is one bus-idle cycle between accesses. A core request arriving in DMA state waits for the DMA completion plus one IDLE cycle.
- `busReady` is ignored in IDLE.

## Configuration
- Macro: `DBUS_ARB_TIMEOUT_EN`.
- **Defined:** a 10-bit wait counter is cleared on entry to CORE/DMA and increments each cycle with `busReady` = 0. On reaching `TIMEOUT_CYCLES` the access aborts:
  - `busError` pulses for 1 cycle.
  - The completion behaves as normal (`coreStall` drops, or `dmaGnt` pulses), with read data forced to 0.
  - Next state is IDLE.
- **Undefined:** the arbiter waits indefinitely for `busReady`, `busError` is tied to 0, and no counter is instantiated.

## Test plan
- **Core load, 2 wait states.** `coreLdSignal` = 1, `coreAddr`=0x100, `busReady` low for 2 cycles then high with `busRData`=0xDEADBEEF. Required: `coreStall` high for 3 cycles; `coreLdData`=0xDEADBEEF in the completion cycle; `busRdEn` high for exactly 3 cycles.
- **Core store.** `coreStSignal` = 1, mask 0x3, data 0x1234, `busReady` = 1 constantly. Required: `busWrEn` = 1 and `busMask`=0x3 for one cycle; `coreStall` high for exactly 1 cycle.
- **Starvation bound.** `dmaReq` held with a continuous stream of core loads, `STARVE_LIMIT`=4, `busReady` = 1. Required: exactly 4 core grants, then a DMA grant with `dmaGnt` pulse, then core resumes.
- **Simultaneous arrival.** Core and DMA requests in the same IDLE cycle, `starveCnt`=0. Required: core served first; DMA granted at the next IDLE cycle; `dmaRData` = `busRData`.
- **Reset mid-access.** `arstn` low during CORE with `busReady` = 0. Required: the next cycle has all bus enables 0 and state IDLE; no `dmaGnt`; `coreStall` = 0 while in reset.
- **Timeout (with `DBUS_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8).** DMA read with `busReady` never high. Required: `busError` and `dmaGnt` pulse together 8 cycles after the bus enable rises; `dmaRData`=0.
